// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares one external memory port between ICache refill, DCache refill and
//   DCache dirty-line writeback. One line burst is in flight at a time.
//   Priority is dc_wr > dc_rd > ic_rd. An ICache request that has already lost
//   two D-side grants in a row wins the next arbitration.
//
//   Ports
//     clk, rst                 clock (rising edge), async active-high reset
//     ic_rd_*                  ICache refill: req/addr in; gnt/valid/last/data out
//     dc_rd_*                  DCache refill: same shape as ic_rd_*
//     dc_wr_*                  DCache writeback: req/addr/data in; gnt/ready/done out
//     mem_req/we/addr/len      address phase to memory, mem_ack accepts it
//     mem_rvalid/rdata         read beats from memory
//     mem_wvalid/wdata/wready  write beats to memory
//     mem_bvalid               write response from memory
module cache_mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_rd_req,
  input  logic [ADDR_W-1:0] ic_rd_addr,
  output logic              ic_rd_gnt,
  output logic              ic_rd_valid,
  output logic              ic_rd_last,
  output logic [DATA_W-1:0] ic_rd_data,
  input  logic              dc_rd_req,
  input  logic [ADDR_W-1:0] dc_rd_addr,
  output logic              dc_rd_gnt,
  output logic              dc_rd_valid,
  output logic              dc_rd_last,
  output logic [DATA_W-1:0] dc_rd_data,
  input  logic              dc_wr_req,
  input  logic [ADDR_W-1:0] dc_wr_addr,
  input  logic [DATA_W-1:0] dc_wr_data,
  output logic              dc_wr_gnt,
  output logic              dc_wr_ready,
  output logic              dc_wr_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_len,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wvalid,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wready,
  input  logic              mem_bvalid
);
  localparam int CNT_W = $clog2(BURST_LEN);
  localparam int OFF_W = $clog2(BURST_LEN * DATA_W / 8);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_RDATA, S_WDATA, S_WRESP} state_t;
  typedef enum logic [1:0] {OWN_IC = 2'd0, OWN_DC_RD = 2'd1, OWN_DC_WR = 2'd2} owner_t;

  state_t            state, state_nxt;
  owner_t            owner, owner_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [CNT_W-1:0]  beat_cnt, beat_nxt;
  logic [1:0]        starve, starve_nxt;
  logic              addr_first, first_nxt;

  assign mem_len = 8'(BURST_LEN - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= OWN_IC;
      addr_q     <= '0;
      beat_cnt   <= '0;
      starve     <= '0;
      addr_first <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      addr_q     <= addr_nxt;
      beat_cnt   <= beat_nxt;
      starve     <= starve_nxt;
      addr_first <= first_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    addr_nxt    = addr_q;
    beat_nxt    = beat_cnt;
    first_nxt   = 1'b0;
    // starvation history only matters while ICache keeps asking
    starve_nxt  = ic_rd_req ? starve : 2'd0;
    ic_rd_gnt   = 1'b0;
    ic_rd_valid = 1'b0;
    ic_rd_last  = 1'b0;
    ic_rd_data  = '0;
    dc_rd_gnt   = 1'b0;
    dc_rd_valid = 1'b0;
    dc_rd_last  = 1'b0;
    dc_rd_data  = '0;
    dc_wr_gnt   = 1'b0;
    dc_wr_ready = 1'b0;
    dc_wr_done  = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wvalid  = 1'b0;
    mem_wdata   = '0;

    case (state)
      S_IDLE: begin
        if (ic_rd_req || dc_rd_req || dc_wr_req) begin
          state_nxt = S_ADDR;
          first_nxt = 1'b1;
          if (ic_rd_req && (starve == 2'd2 || !(dc_wr_req || dc_rd_req))) begin
            owner_nxt  = OWN_IC;
            addr_nxt   = ic_rd_addr;
            starve_nxt = 2'd0;
          end else begin
            if (dc_wr_req) begin
              owner_nxt = OWN_DC_WR;
              addr_nxt  = dc_wr_addr;
            end else begin
              owner_nxt = OWN_DC_RD;
              addr_nxt  = dc_rd_addr;
            end
            if (ic_rd_req && starve != 2'd2) starve_nxt = starve + 2'd1;
          end
        end
      end
      S_ADDR: begin
        ic_rd_gnt = addr_first && (owner == OWN_IC);
        dc_rd_gnt = addr_first && (owner == OWN_DC_RD);
        dc_wr_gnt = addr_first && (owner == OWN_DC_WR);
        mem_req   = 1'b1;
        mem_we    = (owner == OWN_DC_WR);
        mem_addr  = addr_q & LINE_MASK;
        if (mem_ack) begin
          beat_nxt  = '0;
          state_nxt = (owner == OWN_DC_WR) ? S_WDATA : S_RDATA;
        end
      end
      S_RDATA: begin
        // beats pass straight through to the owning cache
        if (owner == OWN_IC) begin
          ic_rd_valid = mem_rvalid;
          ic_rd_data  = mem_rdata;
          ic_rd_last  = mem_rvalid && (beat_cnt == LAST_BEAT);
        end else begin
          dc_rd_valid = mem_rvalid;
          dc_rd_data  = mem_rdata;
          dc_rd_last  = mem_rvalid && (beat_cnt == LAST_BEAT);
        end
        if (mem_rvalid) begin
          beat_nxt = beat_cnt + CNT_W'(1);
          if (beat_cnt == LAST_BEAT) state_nxt = S_IDLE;
        end
      end
      S_WDATA: begin
        mem_wvalid  = 1'b1;
        mem_wdata   = dc_wr_data;
        dc_wr_ready = mem_wready;
        if (mem_wready) begin
          beat_nxt = beat_cnt + CNT_W'(1);
          if (beat_cnt == LAST_BEAT) state_nxt = S_WRESP;
        end
      end
      S_WRESP: begin
        dc_wr_done = mem_bvalid;
        if (mem_bvalid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
//   Directed scenarios with randomized data, handshake timing and request
//   mixes. A transaction-level model of the memory port (who should win,
//   which beats go where, when the write response is due) predicts every
//   output each cycle. Inputs change on the falling edge, outputs are sampled
//   1 time unit later.
module tb_cache_mem_arbiter;
  localparam int AW = 32, DW = 32, BL = 4;
  localparam logic [AW-1:0] AMASK = ~32'hF;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_rd_req, ic_rd_gnt, ic_rd_valid, ic_rd_last;
  logic [AW-1:0] ic_rd_addr;
  logic [DW-1:0] ic_rd_data;
  logic          dc_rd_req, dc_rd_gnt, dc_rd_valid, dc_rd_last;
  logic [AW-1:0] dc_rd_addr;
  logic [DW-1:0] dc_rd_data;
  logic          dc_wr_req, dc_wr_gnt, dc_wr_ready, dc_wr_done;
  logic [AW-1:0] dc_wr_addr;
  logic [DW-1:0] dc_wr_data;
  logic          mem_req, mem_we, mem_ack, mem_rvalid, mem_wvalid, mem_wready, mem_bvalid;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_len;
  logic [DW-1:0] mem_rdata, mem_wdata;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst),
    .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_gnt(ic_rd_gnt),
    .ic_rd_valid(ic_rd_valid), .ic_rd_last(ic_rd_last), .ic_rd_data(ic_rd_data),
    .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_gnt(dc_rd_gnt),
    .dc_rd_valid(dc_rd_valid), .dc_rd_last(dc_rd_last), .dc_rd_data(dc_rd_data),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
    .dc_wr_gnt(dc_wr_gnt), .dc_wr_ready(dc_wr_ready), .dc_wr_done(dc_wr_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata), .mem_wready(mem_wready),
    .mem_bvalid(mem_bvalid)
  );

  int n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_RD, P_WR, P_WRESP} ph_t;
  ph_t           ph;
  logic [2:0]    req;            // 0 = ic_rd, 1 = dc_rd, 2 = dc_wr
  logic [AW-1:0] addr [3];
  int            starve_m, own, ack_wait, ack_fix, beat, wbeat, bwait, bdelay, rearm;
  logic [AW-1:0] own_addr, last_maddr;
  logic [DW-1:0] wline [BL];
  logic          first, rv_always;
  bit            wr_pat [$];
  int            glog [$];
  int            ic_beats, ic_lasts, rd_bursts, wr_bursts;

  function automatic int pick(input logic [2:0] r, input int s);
    if (r[0] && s == 2) return 0;
    if (r[2]) return 2;
    if (r[1]) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    ph = P_IDLE; req = '0; starve_m = 0; own = 0; first = 1'b0;
    beat = 0; wbeat = 0; bwait = 0; rearm = 0; rv_always = 1'b0;
    wr_pat.delete();
  endtask

  task automatic cycle();
    logic [2:0] r_now, g;
    logic       exp_icv, exp_dcv, granted;
    @(negedge clk);
    ic_rd_req  = req[0]; dc_rd_req = req[1]; dc_wr_req = req[2];
    ic_rd_addr = addr[0]; dc_rd_addr = addr[1]; dc_wr_addr = addr[2];
    mem_ack    = (ph == P_ADDR) && (ack_wait == 0);
    mem_rvalid = rv_always || ($urandom_range(0, 2) != 0);
    mem_rdata  = $urandom;
    if (ph == P_WR && wr_pat.size() > 0) mem_wready = wr_pat.pop_front();
    else mem_wready = 1'($urandom_range(0, 1));
    mem_bvalid = (ph == P_WRESP) ? (bwait == 0) : ($urandom_range(0, 5) == 0);
    dc_wr_data = (ph == P_WR) ? wline[wbeat] : $urandom;
    r_now = {dc_wr_req, dc_rd_req, ic_rd_req};
    #1;
    g = {dc_wr_gnt, dc_rd_gnt, ic_rd_gnt};
    chk("gnt", 64'(g), 64'((ph == P_ADDR && first) ? 3'(1 << own) : 3'b000));
    for (int i = 0; i < 3; i++) if (g[i]) begin glog.push_back(i); req[i] = 1'b0; end
    chk("mem_req", 64'(mem_req), 64'(ph == P_ADDR));
    if (ph == P_ADDR) begin
      chk("mem_we", 64'(mem_we), 64'(own == 2));
      chk("mem_addr", 64'(mem_addr), 64'(own_addr & AMASK));
      chk("mem_len", 64'(mem_len), 64'(BL - 1));
    end
    exp_icv = (ph == P_RD) && (own == 0) && mem_rvalid;
    exp_dcv = (ph == P_RD) && (own == 1) && mem_rvalid;
    chk("ic_rd_valid", 64'(ic_rd_valid), 64'(exp_icv));
    chk("dc_rd_valid", 64'(dc_rd_valid), 64'(exp_dcv));
    chk("ic_rd_last", 64'(ic_rd_last), 64'(exp_icv && beat == BL - 1));
    chk("dc_rd_last", 64'(dc_rd_last), 64'(exp_dcv && beat == BL - 1));
    if (exp_icv) chk("ic_rd_data", 64'(ic_rd_data), 64'(mem_rdata));
    if (exp_dcv) chk("dc_rd_data", 64'(dc_rd_data), 64'(mem_rdata));
    if (ic_rd_valid) ic_beats++;
    if (ic_rd_last) ic_lasts++;
    chk("mem_wvalid", 64'(mem_wvalid), 64'(ph == P_WR));
    chk("dc_wr_ready", 64'(dc_wr_ready), 64'(ph == P_WR && mem_wready));
    if (ph == P_WR) chk("mem_wdata", 64'(mem_wdata), 64'(wline[wbeat]));
    chk("dc_wr_done", 64'(dc_wr_done), 64'(ph == P_WRESP && mem_bvalid));

    granted = 1'b0;
    case (ph)
      P_IDLE: if (r_now != 3'b000) begin
        own = pick(r_now, starve_m);
        own_addr = addr[own];
        if (own == 0) starve_m = 0;
        else if (r_now[0]) starve_m = (starve_m < 2) ? starve_m + 1 : 2;
        else starve_m = 0;
        granted = 1'b1;
        ph = P_ADDR; first = 1'b1;
        ack_wait = (ack_fix >= 0) ? ack_fix : $urandom_range(0, 2);
        for (int i = 0; i < BL; i++) wline[i] = $urandom;
      end
      P_ADDR: begin
        first = 1'b0;
        if (mem_ack) begin
          last_maddr = mem_addr;
          ph = (own == 2) ? P_WR : P_RD; beat = 0; wbeat = 0;
        end else ack_wait--;
      end
      P_RD: if (mem_rvalid) begin
        if (beat == BL - 1) begin
          ph = P_IDLE; rd_bursts++;
          if (own == 1 && rearm > 0) begin req[1] = 1'b1; addr[1] = $urandom; rearm--; end
        end else beat++;
      end
      P_WR: if (mem_wready) begin
        wbeat++;
        if (wbeat == BL) begin ph = P_WRESP; bwait = bdelay; wbeat = 0; end
      end
      P_WRESP: if (mem_bvalid) begin ph = P_IDLE; wr_bursts++; end else bwait--;
      default: ph = P_IDLE;
    endcase
    if (!granted && !r_now[0]) starve_m = 0;
  endtask

  task automatic run(input string tag, input int budget);
    int n = 0;
    while ((req != 3'b000 || ph != P_IDLE || rearm != 0) && n < budget) begin
      cycle(); n++;
    end
    chk(tag, 64'(n >= budget), 64'(0));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk(tag, 64'({ic_rd_gnt, ic_rd_valid, ic_rd_last, dc_rd_gnt, dc_rd_valid, dc_rd_last,
                  dc_wr_gnt, dc_wr_ready, dc_wr_done, mem_req, mem_we, mem_wvalid}), 64'(0));
    chk({tag, "_data"}, 64'(ic_rd_data | dc_rd_data | mem_wdata), 64'(0));
    chk({tag, "_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_len"}, 64'(mem_len), 64'(BL - 1));
  endtask

  task automatic drive_quiet();
    ic_rd_req = 0; dc_rd_req = 0; dc_wr_req = 0;
    ic_rd_addr = '0; dc_rd_addr = '0; dc_wr_addr = '0; dc_wr_data = '0;
    mem_ack = 0; mem_rvalid = 0; mem_rdata = '0; mem_wready = 0; mem_bvalid = 0;
  endtask

  initial begin
    int n, ic0, rd0;
    rst = 1'b1;
    drive_quiet();
    model_reset();
    ack_fix = -1; bdelay = 1;
    ic_beats = 0; ic_lasts = 0; rd_bursts = 0; wr_bursts = 0;
    for (int i = 0; i < 3; i++) addr[i] = '0;
    @(negedge clk); #1;
    chk_outputs_zero("reset_outputs");
    @(negedge clk); rst = 1'b0;

    // 1: single ICache refill, ack in first ADDR cycle
    addr[0] = 32'h1C000014; req[0] = 1'b1; ack_fix = 0; glog.delete();
    run("t1_budget", 100);
    chk("t1_addr", 64'(last_maddr), 64'(32'h1C000010));
    chk("t1_beats", 64'(ic_beats), 64'(4));
    chk("t1_lasts", 64'(ic_lasts), 64'(1));
    chk("t1_gnts", 64'(glog.size()), 64'(1));

    // 2: all three requesters at once
    glog.delete(); ack_fix = -1;
    for (int i = 0; i < 3; i++) addr[i] = $urandom;
    req = 3'b111;
    run("t2_budget", 300);
    chk("t2_count", 64'(glog.size()), 64'(3));
    if (glog.size() == 3) begin
      chk("t2_first", 64'(glog[0]), 64'(2));
      chk("t2_second", 64'(glog[1]), 64'(1));
      chk("t2_third", 64'(glog[2]), 64'(0));
    end

    // 3: DCache refills keep coming while ICache waits
    glog.delete();
    addr[0] = $urandom; addr[1] = $urandom;
    req = 3'b011; rearm = 2;
    run("t3_budget", 400);
    chk("t3_count", 64'(glog.size()), 64'(4));
    if (glog.size() == 4) begin
      chk("t3_g0", 64'(glog[0]), 64'(1));
      chk("t3_g1", 64'(glog[1]), 64'(1));
      chk("t3_g2", 64'(glog[2]), 64'(0));
    end

    // 4: writeback with a stalling wready pattern and late response
    wr_bursts = 0; ack_fix = 1; bdelay = 3;
    wr_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    addr[2] = 32'h8000_0024; req[2] = 1'b1;
    run("t4_budget", 100);
    chk("t4_bursts", 64'(wr_bursts), 64'(1));
    chk("t4_pat_used", 64'(wr_pat.size()), 64'(0));
    chk("t4_addr", 64'(last_maddr), 64'(32'h8000_0020));

    // 5: read beats from memory while idle or before ack must go nowhere
    rv_always = 1'b1; ic_beats = 0;
    for (int i = 0; i < 4; i++) cycle();
    ack_fix = 3; addr[0] = $urandom; req[0] = 1'b1;
    run("t5_budget", 100);
    chk("t5_beats", 64'(ic_beats), 64'(4));
    rv_always = 1'b0; ack_fix = -1;

    // 6: reset in the middle of a refill
    addr[0] = $urandom; req[0] = 1'b1;
    n = 0;
    while (!(ph == P_RD && beat == 2) && n < 200) begin cycle(); n++; end
    chk("t6_reach", 64'(n >= 200), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    drive_quiet();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; mem_ack = 1'b1;
    mem_wready = 1'b1; mem_bvalid = 1'b1; dc_wr_data = 32'h1234_5678;
    #1;
    chk_outputs_zero("t6_rst");
    model_reset();
    @(negedge clk); rst = 1'b0; drive_quiet();
    ic0 = ic_lasts; rd0 = rd_bursts;
    addr[0] = $urandom; req[0] = 1'b1;
    run("t6_budget", 100);
    chk("t6_refill", 64'(rd_bursts - rd0), 64'(1));
    chk("t6_last", 64'(ic_lasts - ic0), 64'(1));

    // random mixes of requesters, timing and rearmed DCache refills
    for (int r = 0; r < 25; r++) begin
      ack_fix = -1; bdelay = $urandom_range(0, 3);
      for (int i = 0; i < 3; i++) addr[i] = $urandom;
      req = 3'($urandom_range(1, 7));
      rearm = req[1] ? $urandom_range(0, 2) : 0;
      run("rand_budget", 600);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
